// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes and access-size decode.
package ysyx_22041211_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Reserved funct3 codes fall through to word accesses.
   function automatic mem_size_e op_size(input logic [2:0] op);
      case (op)
         F3_B, F3_BU: return SZ_BYTE;
         F3_H, F3_HU: return SZ_HALF;
         F3_W:        return SZ_WORD;
         default:     return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational lane logic: store strobes/replication, load extract/extend, misalign detect.
module ysyx_22041211_lsu_align
   import ysyx_22041211_lsu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_ext_o,
   output logic        misalign_o
);

   logic [31:0] rdata_shift;
   logic        is_unsigned;

   assign rdata_shift = rdata_i >> {addr_lo_i, 3'b000};
   assign is_unsigned = op_i[2];

   always_comb begin
      wmask_o     = 4'b0000;
      wdata_o     = store_data_i;
      rdata_ext_o = rdata_i;
      misalign_o  = 1'b0;
      case (op_size(op_i))
         SZ_BYTE: begin
            wmask_o     = 4'b0001 << addr_lo_i;
            wdata_o     = {4{store_data_i[7:0]}};
            rdata_ext_o = {{24{rdata_shift[7] & ~is_unsigned}}, rdata_shift[7:0]};
         end
         SZ_HALF: begin
            wmask_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o     = {2{store_data_i[15:0]}};
            rdata_ext_o = {{16{rdata_shift[15] & ~is_unsigned}}, rdata_shift[15:0]};
            misalign_o  = addr_lo_i[0];
         end
         default: begin
            wmask_o     = 4'b1111;
            wdata_o     = store_data_i;
            rdata_ext_o = rdata_i;
            misalign_o  = (addr_lo_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: one single-beat bus transaction per accepted memory instruction.
//  state   | meaning
//  IDLE    | waiting for ctrl_valid_i && memory_inst_i
//  REQ     | request on bus, held until mem_req_ready_i
//  RESP    | waiting for mem_resp_valid_i
//  DONE    | lsu_valid_o pulse (lsu_err_o if misaligned)
module ysyx_22041211_lsu
   import ysyx_22041211_lsu_pkg::*;
#(
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ctrl_valid_i,
   input  logic                memory_inst_i,
   input  logic                mem_wen_i,
   input  logic [2:0]          mem_op_i,
   input  logic [DATA_LEN-1:0] addr_i,
   input  logic [DATA_LEN-1:0] store_data_i,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic                mem_wen_o,
   output logic [DATA_LEN-1:0] mem_addr_o,
   output logic [DATA_LEN-1:0] mem_wdata_o,
   output logic [3:0]          mem_wmask_o,
   input  logic                mem_resp_valid_i,
   input  logic [DATA_LEN-1:0] mem_rdata_i,
   output logic                lsu_valid_o,
   output logic [DATA_LEN-1:0] load_data_o,
   output logic                lsu_err_o
);

   lsu_state_e          state_q, state_d;
   logic                wen_q;
   logic [2:0]          op_q;
   logic [DATA_LEN-1:0] addr_q;
   logic [DATA_LEN-1:0] sdata_q;
   logic [DATA_LEN-1:0] load_data_q;
   logic                err_q;

   logic                start;
   logic [2:0]          al_op;
   logic [1:0]          al_addr_lo;
   logic [DATA_LEN-1:0] al_sdata;
   logic [3:0]          al_wmask;
   logic [DATA_LEN-1:0] al_wdata;
   logic [DATA_LEN-1:0] al_rdata_ext;
   logic                al_misalign;

   assign start = ctrl_valid_i && memory_inst_i;

   // In IDLE the aligner looks at the incoming operands so misalignment can be
   // decided at the start edge; afterwards it works on the latched copy.
   always_comb begin
      al_op      = op_q;
      al_addr_lo = addr_q[1:0];
      al_sdata   = sdata_q;
      if (state_q == ST_IDLE) begin
         al_op      = mem_op_i;
         al_addr_lo = addr_i[1:0];
         al_sdata   = store_data_i;
      end
   end

   ysyx_22041211_lsu_align u_align (
      .op_i        (al_op),
      .addr_lo_i   (al_addr_lo),
      .store_data_i(al_sdata),
      .rdata_i     (mem_rdata_i),
      .wmask_o     (al_wmask),
      .wdata_o     (al_wdata),
      .rdata_ext_o (al_rdata_ext),
      .misalign_o  (al_misalign)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = al_misalign ? ST_DONE : ST_REQ;
         ST_REQ:  if (mem_req_ready_i) state_d = ST_RESP;
         ST_RESP: if (mem_resp_valid_i) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wen_q       <= 1'b0;
         op_q        <= 3'b000;
         addr_q      <= '0;
         sdata_q     <= '0;
         load_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            wen_q       <= mem_wen_i;
            op_q        <= mem_op_i;
            addr_q      <= addr_i;
            sdata_q     <= store_data_i;
            err_q       <= al_misalign;
            load_data_q <= '0;
         end
         if (state_q == ST_RESP && mem_resp_valid_i && !wen_q) begin
            load_data_q <= al_rdata_ext;
         end
      end
   end

   always_comb begin
      mem_req_valid_o = 1'b0;
      mem_wen_o       = 1'b0;
      mem_addr_o      = '0;
      mem_wdata_o     = '0;
      mem_wmask_o     = 4'b0000;
      if (state_q == ST_REQ) begin
         mem_req_valid_o = 1'b1;
         mem_wen_o       = wen_q;
         mem_addr_o      = {addr_q[DATA_LEN-1:2], 2'b00};
         if (wen_q) begin
            mem_wdata_o = al_wdata;
            mem_wmask_o = al_wmask;
         end
      end
   end

   assign lsu_valid_o = (state_q == ST_DONE);
   assign lsu_err_o   = (state_q == ST_DONE) && err_q;
   assign load_data_o = load_data_q;

endmodule
